// File: rtl/universal_shift_register.sv
// N-bit universal shift register: bidirectional shift/rotate, parallel load,
// serial taps at both ends and a frame counter that pulses every WIDTH shifts.
module universal_shift_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set,
  input  logic                         ce,
  input  logic                         we,
  input  logic [2:0]                   mode,
  input  logic                         sin_msb,
  input  logic                         sin_lsb,
  input  logic [WIDTH-1:0]             pdata,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_lsb,
  output logic                         sout_msb,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         frame_done
);

  localparam int CW = $clog2(WIDTH+1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_q, frame_d;

  logic [WIDTH-1:0] shr_vec, shl_vec, ror_vec, rol_vec;
  logic             op_en;
  logic             is_shift;
  logic             cnt_last;

  // Candidate next values for each direction, built per bit so the end bits
  // pick up either the serial input or the wrapped-around bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
    if (gi == WIDTH - 1) begin : g_top
      assign shr_vec[gi] = sin_msb;
      assign ror_vec[gi] = data_q[0];
    end else begin : g_top_inner
      assign shr_vec[gi] = data_q[gi+1];
      assign ror_vec[gi] = data_q[gi+1];
    end

    if (gi == 0) begin : g_bot
      assign shl_vec[gi] = sin_lsb;
      assign rol_vec[gi] = data_q[WIDTH-1];
    end else begin : g_bot_inner
      assign shl_vec[gi] = data_q[gi-1];
      assign rol_vec[gi] = data_q[gi-1];
    end
  end

  assign op_en    = ce && we;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    is_shift = 1'b0;
    case (mode)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: is_shift = 1'b1;
      default:                                is_shift = 1'b0;
    endcase
  end

  // Next-state selection; reset is handled in the register process and has
  // the final word over everything computed here.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;

    if (set) begin
      data_d = {WIDTH{1'b1}};
      cnt_d  = '0;
    end else if (op_en) begin
      case (mode)
        MODE_SHR:  data_d = shr_vec;
        MODE_SHL:  data_d = shl_vec;
        MODE_ROR:  data_d = ror_vec;
        MODE_ROL:  data_d = rol_vec;
        MODE_LOAD: begin
          data_d = pdata;
          cnt_d  = '0;
        end
        MODE_HOLD: data_d = data_q;
        default:   data_d = data_q;
      endcase

      if (is_shift) begin
        if (cnt_last) begin
          cnt_d   = '0;
          frame_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE;
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign q          = data_q;
  assign sout_lsb   = data_q[0];
  assign sout_msb   = data_q[WIDTH-1];
  assign bit_cnt    = cnt_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed test of universal_shift_register (WIDTH=8) against a behavioural
// model checked every cycle, plus hand-computed literal expectations.
module tb_universal_shift_register;

  localparam int          W   = 8;
  localparam logic [7:0]  RV  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, set, ce, we;
  logic [2:0] mode;
  logic       sin_msb, sin_lsb;
  logic [7:0] pdata;
  logic [7:0] q;
  logic       sout_lsb, sout_msb;
  logic [3:0] bit_cnt;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .ce         (ce),
    .we         (we),
    .mode       (mode),
    .sin_msb    (sin_msb),
    .sin_lsb    (sin_lsb),
    .pdata      (pdata),
    .q          (q),
    .sout_lsb   (sout_lsb),
    .sout_msb   (sout_msb),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: register as an integer value, shift count as an
  // integer counted modulo the frame length.
  typedef struct packed {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       fd;
  } model_t;

  model_t m;
  logic   m_valid = 1'b0;

  function automatic model_t model_next(model_t cur);
    model_t nx;
    int     v;
    int     shifts;
    bit     shifted;
    nx      = cur;
    nx.fd   = 1'b0;
    v       = int'(cur.q);
    shifted = 1'b0;
    if (reset) begin
      nx.q = RV; nx.cnt = 0;
    end else if (set) begin
      nx.q = 8'hFF; nx.cnt = 0;
    end else if (ce && we) begin
      case (mode)
        3'd1: begin v = (v / 2) + (sin_msb ? 128 : 0); shifted = 1; end
        3'd2: begin v = ((v * 2) % 256) + (sin_lsb ? 1 : 0); shifted = 1; end
        3'd3: begin v = (v / 2) + ((v % 2) * 128); shifted = 1; end
        3'd4: begin v = ((v * 2) % 256) + (v / 128); shifted = 1; end
        3'd5: begin v = int'(pdata); nx.cnt = 0; end
        default: ;
      endcase
      nx.q = v[7:0];
      if (shifted) begin
        shifts = int'(cur.cnt) + 1;
        nx.fd  = (shifts == W);
        nx.cnt = 4'(shifts % W);
      end
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m       <= model_next(m);
    if (reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", q, m.q);
      check("model_cnt", bit_cnt, m.cnt);
      check("model_frame", frame_done, m.fd);
      check("model_sout_lsb", sout_lsb, m.q[0]);
      check("model_sout_msb", sout_msb, m.q[7]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] md, input logic sm, input logic sl);
    mode = md; sin_msb = sm; sin_lsb = sl;
    cyc();
  endtask

  task automatic load(input logic [7:0] d);
    mode = 3'd5; pdata = d;
    cyc();
  endtask

  logic [7:0] shr_pat;
  int         pulses;

  initial begin
    m = '0;
    reset = 1; set = 1; ce = 1; we = 1; mode = 3'd5; pdata = 8'h3C;
    sin_msb = 0; sin_lsb = 0;
    cyc();
    $display("reset+set+load: q=%0h cnt=%0d fd=%0b", q, bit_cnt, frame_done);
    check("reset_q", q, 8'hA5);
    check("reset_cnt", bit_cnt, 0);
    check("reset_fd", frame_done, 0);
    reset = 0; set = 0;

    load(8'h00);
    set = 1; ce = 0;
    cyc();
    $display("set with ce=0: q=%0h cnt=%0d", q, bit_cnt);
    check("set_q", q, 8'hFF);
    check("set_cnt", bit_cnt, 0);
    set = 0; ce = 1;

    load(8'h00);
    shr_pat = 8'b0100_1101; // bit i is the i-th serial bit: 1,0,1,1,0,0,1,0
    for (int i = 0; i < 8; i++) begin
      op(3'd1, shr_pat[i], 1'b0);
      $display("SHR %0d: q=%0h cnt=%0d fd=%0b", i, q, bit_cnt, frame_done);
      check("shr_cnt", bit_cnt, 4'((i + 1) % 8));
      check("shr_fd", frame_done, (i == 7));
    end
    check("shr_q", q, 8'h4D);
    op(3'd0, 0, 0);
    check("shr_fd_clear", frame_done, 0);

    load(8'h81);
    op(3'd4, 0, 0);
    $display("ROL: q=%0h msb=%0b lsb=%0b", q, sout_msb, sout_lsb);
    check("rol_q", q, 8'h03);
    check("rol_msb", sout_msb, 0);
    check("rol_lsb", sout_lsb, 1);
    op(3'd3, 0, 0);
    op(3'd3, 0, 0);
    $display("ROR x2: q=%0h cnt=%0d", q, bit_cnt);
    check("ror_q", q, 8'hC0);
    check("ror_cnt", bit_cnt, 3);

    op(3'd2, 0, 0);
    op(3'd2, 0, 0);
    check("gate_pre_cnt", bit_cnt, 5);
    we = 0;
    for (int i = 0; i < 3; i++) op(3'd2, 0, 1);
    we = 1; ce = 0;
    for (int i = 0; i < 2; i++) op(3'd2, 0, 1);
    $display("gated: q=%0h cnt=%0d fd=%0b", q, bit_cnt, frame_done);
    check("gate_q", q, 8'h00);
    check("gate_cnt", bit_cnt, 5);
    check("gate_fd", frame_done, 0);
    ce = 1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      op(3'd2, 0, 1);
      if (frame_done) pulses++;
    end
    op(3'd0, 0, 0);
    if (frame_done) pulses++;
    $display("re-enable: q=%0h cnt=%0d pulses=%0d", q, bit_cnt, pulses);
    check("reen_q", q, 8'h07);
    check("reen_pulses", pulses, 1);

    for (int i = 0; i < 7; i++) op(3'd2, 0, 0);
    check("pre_load_cnt", bit_cnt, 7);
    load(8'h5A);
    $display("load at cnt=7: q=%0h cnt=%0d fd=%0b", q, bit_cnt, frame_done);
    check("loadcol_q", q, 8'h5A);
    check("loadcol_cnt", bit_cnt, 0);
    check("loadcol_fd", frame_done, 0);

    op(3'd1, 0, 0);
    op(3'd7, 1, 1);
    op(3'd6, 1, 1);
    $display("reserved: q=%0h cnt=%0d", q, bit_cnt);
    check("rsv_q", q, 8'h2D);
    check("rsv_cnt", bit_cnt, 1);

    for (int i = 0; i < 6; i++) op(3'd1, 0, 0);
    check("pre_reset_cnt", bit_cnt, 7);
    reset = 1;
    op(3'd1, 1, 0);
    reset = 0;
    $display("reset at cnt=7: q=%0h cnt=%0d fd=%0b", q, bit_cnt, frame_done);
    check("rstcol_q", q, 8'hA5);
    check("rstcol_cnt", bit_cnt, 0);
    check("rstcol_fd", frame_done, 0);

    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      op(3'd4, 0, 0);
      if (frame_done) pulses++;
    end
    $display("16 ROL: q=%0h pulses=%0d", q, pulses);
    check("b2b_q", q, 8'hA5);
    check("b2b_pulses", pulses, 2);

    set = 1;
    op(3'd1, 0, 0);
    set = 0;
    check("set_mid_q", q, 8'hFF);
    op(3'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
